alu_exec_unit: RTL

Multi-cycle RV32I integer execution unit driving the register-file ports: it issues the two source-register selects, captures the operands, computes the ALU result and drives the destination-register write port. It sits between the instruction fetch/decode front end (valid/ready instruction handshake) and the register file. It is the initiator of the register-file read/write protocol. It supports the OP, OP-IMM and LUI instruction classes only.

---
 rtl/rv32_pkg.sv | 41 ++++
 rtl/alu_core.sv | 29 ++
 rtl/alu_exec_unit.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32I encoding constants and enums for the integer execution unit.
package rv32_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PASS_B
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WB
    } exec_state_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational RV32I ALU; shifts use only the low 5 bits of b.
module alu_core
    import rv32_pkg::*;
(
    input  alu_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    always_comb begin
        y = 32'h0;
        case (op)
            ALU_ADD:    y = a + b;
            ALU_SUB:    y = a - b;
            ALU_SLL:    y = a << b[4:0];
            ALU_SLT:    y = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU:   y = {31'b0, a < b};
            ALU_XOR:    y = a ^ b;
            ALU_SRL:    y = a >> b[4:0];
            ALU_SRA:    y = $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:     y = a | b;
            ALU_AND:    y = a & b;
            ALU_PASS_B: y = b;
            default:    y = 32'h0;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Four-state (IDLE/READ/EXEC/WB) RV32I OP/OP-IMM/LUI execution unit that
// initiates register-file reads and the single-cycle write-back strobe.
module alu_exec_unit
    import rv32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    output logic [4:0]  reg_rs1_select,
    output logic [4:0]  reg_rs2_select,
    input  logic [31:0] reg_rs1,
    input  logic [31:0] reg_rs2,
    output logic        reg_rd_valid,
    output logic [4:0]  reg_rd_select,
    output logic [31:0] reg_rd,
    output logic        done,
    output logic        illegal
);

    exec_state_e state_reg, state_next;
    logic [31:0] instr_q, op_a, op_b, result_q;
    logic        illegal_q;

    alu_op_e     alu_op;
    logic [31:0] alu_b, alu_y;
    logic        dec_illegal;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [31:0] imm_i, imm_u;

    assign opcode = instr_q[6:0];
    assign funct3 = instr_q[14:12];
    assign funct7 = instr_q[31:25];
    assign imm_i  = {{20{instr_q[31]}}, instr_q[31:20]};
    assign imm_u  = {instr_q[31:12], 12'h0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (instr_valid) state_next = ST_READ;
            ST_READ: state_next = ST_EXEC;
            ST_EXEC: state_next = ST_WB;
            ST_WB:   state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Write-back strobes are decoded from state only, never from instr/instr_valid.
    always_comb begin
        instr_ready  = (state_reg == ST_IDLE);
        done         = (state_reg == ST_WB);
        illegal      = (state_reg == ST_WB) && illegal_q;
        reg_rd_valid = (state_reg == ST_WB) && !illegal_q && (instr_q[11:7] != 5'd0);
    end

    assign reg_rs1_select = instr_q[19:15];
    assign reg_rs2_select = instr_q[24:20];
    assign reg_rd_select  = instr_q[11:7];
    assign reg_rd         = result_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q   <= 32'h0;
            op_a      <= 32'h0;
            op_b      <= 32'h0;
            result_q  <= 32'h0;
            illegal_q <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: if (instr_valid) instr_q <= instr;
                ST_READ: begin
                    op_a <= reg_rs1;
                    op_b <= reg_rs2;
                end
                ST_EXEC: begin
                    result_q  <= alu_y;
                    illegal_q <= dec_illegal;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        alu_op      = ALU_ADD;
        alu_b       = op_b;
        dec_illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        F3_ADD_SUB: alu_op = ALU_ADD;
                        F3_SLL:     alu_op = ALU_SLL;
                        F3_SLT:     alu_op = ALU_SLT;
                        F3_SLTU:    alu_op = ALU_SLTU;
                        F3_XOR:     alu_op = ALU_XOR;
                        F3_SRL_SRA: alu_op = ALU_SRL;
                        F3_OR:      alu_op = ALU_OR;
                        default:    alu_op = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) begin
                    alu_op = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == F3_SRL_SRA) begin
                    alu_op = ALU_SRA;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                // Shift-immediate amount is instr[24:20], i.e. imm_i[4:0].
                alu_b = imm_i;
                case (funct3)
                    F3_ADD_SUB: alu_op = ALU_ADD;
                    F3_SLT:     alu_op = ALU_SLT;
                    F3_SLTU:    alu_op = ALU_SLTU;
                    F3_XOR:     alu_op = ALU_XOR;
                    F3_OR:      alu_op = ALU_OR;
                    F3_AND:     alu_op = ALU_AND;
                    F3_SLL: begin
                        alu_op      = ALU_SLL;
                        dec_illegal = (funct7 != F7_BASE);
                    end
                    default: begin
                        if (funct7 == F7_BASE)     alu_op = ALU_SRL;
                        else if (funct7 == F7_ALT) alu_op = ALU_SRA;
                        else                       dec_illegal = 1'b1;
                    end
                endcase
            end
            OPC_LUI: begin
                alu_op = ALU_PASS_B;
                alu_b  = imm_u;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    alu_core u_alu_core (
        .op (alu_op),
        .a  (op_a),
        .b  (alu_b),
        .y  (alu_y)
    );

endmodule
